ex_hazard_ctrl: RTL and testbench
=================================

// Module: ex_hazard_ctrl
// PURPOSE
//  Sequencing controller for the EX stage of the 5-stage pipeline.
//  - Drives the A/B operand-forwarding selects.
//  - Inserts load-use bubbles.
//  - Freezes the pipeline while a multi-cycle ALU op occupies EX.
//  - Kills in-flight work on a taken-branch flush.
//  - Keeps a saturating stall-cycle counter.
//  Sits beside EX; drives PC, IF/ID, ID/EX and EX/MEM enables.
// PARAMETERS
//  MC_CYCLES  4   cycles a multi-cycle op occupies EX; legal range 2..15.
//  CNT_W      4   width of the multi-cycle down-counter.
//  PERF_W     16  width of stall_cnt.
// PORTS
//  clk           in   1       sole clock, rising edge.
//  rst           in   1       asynchronous reset, active-low (asserted at 0).
//  id_rs,id_rt   in   5       source regs of the instruction in ID.
//  id_uses_rs/rt in   1       ID instruction actually reads rs / rt.
//  ex_valid      in   1       EX holds a real instruction (not a bubble).
//  ex_rs,ex_rt   in   5       source regs of the instruction in EX.
//  ex_alu_src    in   1       1 = B operand is immediate; suppresses B forwarding.
//  ex_dst        in   5       destination of EX (post-RegDst mux).
//  ex_reg_write  in   1       EX writes the register file.
//  ex_mem_read   in   1       EX is a load.
//  ex_mc_op      in   1       EX instruction is multi-cycle.
//  mem_dst       in   5       MEM destination.
//  mem_reg_write in   1       MEM writes the register file.
//  wb_dst        in   5       WB destination.
//  wb_reg_write  in   1       WB writes the register file.
//  flush         in   1       taken branch resolved in MEM.
//  Aforward      out  2       00 regfile, 01 WB WriteData, 10 MEM alu_res.
//  Bforward      out  2       same encoding as Aforward.
//  pc_write      out  1       PC load enable.
//  ifid_write    out  1       IF/ID load enable.
//  ifid_flush    out  1       clear IF/ID.
//  idex_bubble   out  1       load NOP into ID/EX.
//  ex_flush      out  1       load NOP into EX/MEM (kill EX).
//  pipe_hold     out  1       freeze ID/EX, EX/MEM, MEM/WB and the PC.
//  mc_done       out  1       1-cycle pulse: multi-cycle result valid this cycle.
//  stall_cnt     out  PERF_W  saturating count of stalled cycles.
// BEHAVIOUR
//  Forwarding (combinational)
//   - A = 10 if mem_reg_write & mem_dst!=0 & mem_dst==ex_rs.
//   - Else A = 01 if wb_reg_write & wb_dst!=0 & wb_dst==ex_rs.
//   - Else A = 00. MEM has priority over WB.
//   - B uses the same rule with ex_rt; B is forced to 00 when ex_alu_src=1.
//   - Both selects are 00 while rst=0.
//  Load-use hazard
//   - luh = ex_valid & ex_mem_read & ex_dst!=0
//           & ((id_uses_rs & id_rs==ex_dst) | (id_uses_rt & id_rt==ex_dst)).
//   - In RUN with luh: pc_write=0, ifid_write=0, idex_bubble=1.
//   - Exactly one bubble results, because the load moves to MEM next cycle.
//  FSM states: RUN, MC_BUSY. cnt is CNT_W bits.
//   RUN
//    - If ex_valid & ex_mc_op & !flush: pipe_hold=1, pc_write=0, ifid_write=0,
//      cnt<=MC_CYCLES-2, go to MC_BUSY.
//   MC_BUSY
//    - cnt!=0: pipe_hold=1, cnt<=cnt-1.
//    - cnt==0: pipe_hold=0, mc_done=1, go to RUN.
//   - Net effect: EX occupancy is exactly MC_CYCLES cycles; hold lasts MC_CYCLES-1.
//   - Forwarding stays valid during hold because MEM/WB are frozen too.
//  Priority
//   - flush > multi-cycle hold > load-use.
//   - A load-use condition during hold is ignored and re-evaluated after release.
//  Flush (any state)
//   - ifid_flush=1, idex_bubble=1, ex_flush=1, pipe_hold=0, pc_write=1.
//   - In MC_BUSY: abort to RUN, cnt<=0, no mc_done pulse.
//  stall_cnt
//   - Increments on every cycle with pc_write=0; saturates at all-ones.
//  Reset (rst=0, async)
//   - State RUN, cnt=0, stall_cnt=0.
//   - pc_write=1, ifid_write=1; all other outputs 0.
//   - Reset mid-MC_BUSY aborts immediately.
// STRUCTURE
//  - Shared include pipe_defs.vh: FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10,
//    state encodings ST_RUN, ST_MC_BUSY.
//  - Sub-module fwd_sel: combinational compare producing one 2-bit select;
//    instantiated twice (A, B).
// TESTING
//  1. MEM dst=5 and WB dst=5 both writing, ex_rs=5 -> Aforward=10.
//     Clear MEM write -> 01. Use dst=0 -> 00.
//  2. ex_rt=7, mem_dst=7, ex_alu_src=1 -> Bforward=00; ex_alu_src=0 -> 10.
//  3. lw $3 in EX, add reading $3 in ID -> one cycle of pc_write=0, idex_bubble=1.
//     Next cycle no stall; stall_cnt=1.
//  4. mc op enters EX (MC_CYCLES=4) -> pipe_hold=1 for 3 cycles.
//     mc_done on the 4th cycle; stall_cnt +3.
//  5. flush asserted in MC_BUSY cnt=1 -> next cycle RUN, no mc_done.
//     ex_flush=1 and ifid_flush=1 in the flush cycle.
//  6. rst=0 pulse mid-MC_BUSY (async, between edges) -> outputs at reset values
//     immediately; stall_cnt=0.

Source files
------------

// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared encodings for the EX-stage hazard controller: forwarding selects and FSM states.
package ex_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_t;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MC_BUSY = 1'b1
    } state_t;

    // Register $0 is hardwired to zero, so a write to it never produces a hazard.
    function automatic logic dst_hit(input logic we, input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] src);
        return we && (dst != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Pipeline-status inputs and pipeline-control outputs of the EX hazard controller.
interface ex_hazard_ctrl_if #(
    parameter int PERF_W = 16
);
    import ex_hazard_ctrl_pkg::*;

    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              ex_valid;
    logic [REG_W-1:0]  ex_rs;
    logic [REG_W-1:0]  ex_rt;
    logic              ex_alu_src;
    logic [REG_W-1:0]  ex_dst;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mc_op;
    logic [REG_W-1:0]  mem_dst;
    logic              mem_reg_write;
    logic [REG_W-1:0]  wb_dst;
    logic              wb_reg_write;
    logic              flush;

    logic [1:0]        Aforward;
    logic [1:0]        Bforward;
    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              ex_flush;
    logic              pipe_hold;
    logic              mc_done;
    logic [PERF_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_valid, ex_rs, ex_rt, ex_alu_src,
               ex_dst, ex_reg_write, ex_mem_read, ex_mc_op, mem_dst, mem_reg_write,
               wb_dst, wb_reg_write, flush,
        input  Aforward, Bforward, pc_write, ifid_write, ifid_flush, idex_bubble,
               ex_flush, pipe_hold, mc_done, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_valid, ex_rs, ex_rt, ex_alu_src,
               ex_dst, ex_reg_write, ex_mem_read, ex_mc_op, mem_dst, mem_reg_write,
               wb_dst, wb_reg_write, flush,
        output Aforward, Bforward, pc_write, ifid_write, ifid_flush, idex_bubble,
               ex_flush, pipe_hold, mc_done, stall_cnt
    );

endinterface

// File: rtl/ex_hazard_ctrl_fwd_sel.sv
// One operand's forwarding select; MEM result beats WB result.
// Purely combinational; en=0 forces the register-file path.
module ex_hazard_ctrl_fwd_sel
    import ex_hazard_ctrl_pkg::*;
(
    input  logic             en,
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] wb_dst,
    input  logic             wb_reg_write,
    output fwd_t             sel
);

    always_comb begin
        sel = FWD_REG;
        if (en) begin
            if (dst_hit(mem_reg_write, mem_dst, src)) begin
                sel = FWD_MEM;
            end else if (dst_hit(wb_reg_write, wb_dst, src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage sequencer: operand forwarding, load-use bubbles, multi-cycle freeze, flush, stall counter.
// Controls are combinational from current inputs and FSM state; stall_cnt updates one cycle later.
module ex_hazard_ctrl
    import ex_hazard_ctrl_pkg::*;
#(
    parameter int MC_CYCLES = 4,
    parameter int CNT_W     = 4,
    parameter int PERF_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    ex_hazard_ctrl_if.slave  bus
);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [PERF_W-1:0] stall_q;

    logic luh;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, ex_flush, pipe_hold, mc_done;
    fwd_t a_sel, b_sel;

    ex_hazard_ctrl_fwd_sel u_fwd_a (
        .en            (rst),
        .src           (bus.ex_rs),
        .mem_dst       (bus.mem_dst),
        .mem_reg_write (bus.mem_reg_write),
        .wb_dst        (bus.wb_dst),
        .wb_reg_write  (bus.wb_reg_write),
        .sel           (a_sel)
    );

    // An immediate B operand never takes a forwarded register value.
    ex_hazard_ctrl_fwd_sel u_fwd_b (
        .en            (rst && !bus.ex_alu_src),
        .src           (bus.ex_rt),
        .mem_dst       (bus.mem_dst),
        .mem_reg_write (bus.mem_reg_write),
        .wb_dst        (bus.wb_dst),
        .wb_reg_write  (bus.wb_reg_write),
        .sel           (b_sel)
    );

    assign luh = bus.ex_valid && bus.ex_mem_read && (bus.ex_dst != '0)
               && ((bus.id_uses_rs && (bus.id_rs == bus.ex_dst))
                || (bus.id_uses_rt && (bus.id_rt == bus.ex_dst)));

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        ex_flush    = 1'b0;
        pipe_hold   = 1'b0;
        mc_done     = 1'b0;
        if (!rst) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
        end else if (bus.flush) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            ex_flush    = 1'b1;
            state_nxt   = ST_RUN;
            cnt_nxt     = '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (bus.ex_valid && bus.ex_mc_op) begin
                        pipe_hold  = 1'b1;
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        cnt_nxt    = CNT_W'(MC_CYCLES - 2);
                        state_nxt  = ST_MC_BUSY;
                    end else if (luh) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                ST_MC_BUSY: begin
                    // Load-use is not evaluated here; it is re-checked once back in RUN.
                    if (cnt != '0) begin
                        pipe_hold  = 1'b1;
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        cnt_nxt    = cnt - CNT_W'(1);
                    end else begin
                        mc_done   = 1'b1;
                        state_nxt = ST_RUN;
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_RUN;
            cnt     <= '0;
            stall_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (!pc_write && (stall_q != '1)) begin
                stall_q <= stall_q + PERF_W'(1);
            end
        end
    end

    assign bus.Aforward    = a_sel;
    assign bus.Bforward    = b_sel;
    assign bus.pc_write    = pc_write;
    assign bus.ifid_write  = ifid_write;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.ex_flush    = ex_flush;
    assign bus.pipe_hold   = pipe_hold;
    assign bus.mc_done     = mc_done;
    assign bus.stall_cnt   = stall_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: behavioural model compared every cycle, plus directed literal checks.
module tb_ex_hazard_ctrl;
    import ex_hazard_ctrl_pkg::*;

    localparam int MC   = 4;
    localparam int PW   = 16;
    localparam int SMAX = (1 << PW) - 1;

    logic clk;
    logic rst;

    ex_hazard_ctrl_if #(.PERF_W(PW)) bus();

    ex_hazard_ctrl #(.MC_CYCLES(MC), .CNT_W(4), .PERF_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: whether a multi-cycle op occupies EX and how many cycles it has been there.
    bit m_busy  = 1'b0;
    int m_age   = 0;
    int m_stall = 0;
    bit exp_pcw = 1'b1;

    function automatic logic [1:0] fwd_model(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (bus.mem_reg_write && bus.mem_dst == src) return 2'b10;
        if (bus.wb_reg_write && bus.wb_dst == src) return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy  = 1'b0;
            m_age   = 0;
            m_stall = 0;
        end else begin
            if (!exp_pcw && m_stall < SMAX) m_stall++;
            if (bus.flush) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                if (m_age == MC - 1) m_busy = 1'b0;
                else m_age++;
            end else if (bus.ex_valid && bus.ex_mc_op) begin
                m_busy = 1'b1;
                m_age  = 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] ea, eb;
        bit hold, done, ld, fl, pcw, ifw, bub;
        if (!rst) begin
            ea = 2'b00; eb = 2'b00;
            hold = 0; done = 0; ld = 0; fl = 0;
        end else begin
            fl   = bus.flush;
            ea   = fwd_model(bus.ex_rs);
            eb   = bus.ex_alu_src ? 2'b00 : fwd_model(bus.ex_rt);
            hold = !fl && (m_busy ? (m_age < MC - 1) : (bus.ex_valid && bus.ex_mc_op));
            done = !fl && m_busy && (m_age == MC - 1);
            ld   = !fl && !m_busy && !hold && bus.ex_valid && bus.ex_mem_read
                   && bus.ex_dst != 0
                   && ((bus.id_uses_rs && bus.id_rs == bus.ex_dst)
                    || (bus.id_uses_rt && bus.id_rt == bus.ex_dst));
        end
        pcw = !(hold || ld);
        ifw = !(hold || ld);
        bub = fl || ld;
        exp_pcw = pcw;
        check("cmp_Aforward",    32'(bus.Aforward),    32'(ea));
        check("cmp_Bforward",    32'(bus.Bforward),    32'(eb));
        check("cmp_pc_write",    32'(bus.pc_write),    32'(pcw));
        check("cmp_ifid_write",  32'(bus.ifid_write),  32'(ifw));
        check("cmp_ifid_flush",  32'(bus.ifid_flush),  32'(fl));
        check("cmp_idex_bubble", 32'(bus.idex_bubble), 32'(bub));
        check("cmp_ex_flush",    32'(bus.ex_flush),    32'(fl));
        check("cmp_pipe_hold",   32'(bus.pipe_hold),   32'(hold));
        check("cmp_mc_done",     32'(bus.mc_done),     32'(done));
        check("cmp_stall_cnt",   32'(bus.stall_cnt),   32'(rst ? m_stall : 0));
    end

    task automatic clr();
        bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
        bus.ex_valid = 0; bus.ex_rs = '0; bus.ex_rt = '0; bus.ex_alu_src = 0;
        bus.ex_dst = '0; bus.ex_reg_write = 0; bus.ex_mem_read = 0; bus.ex_mc_op = 0;
        bus.mem_dst = '0; bus.mem_reg_write = 0; bus.wb_dst = '0; bus.wb_reg_write = 0;
        bus.flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use(input logic [4:0] r);
        bus.ex_valid = 1; bus.ex_mem_read = 1; bus.ex_reg_write = 1; bus.ex_dst = r;
        bus.id_rs = r; bus.id_uses_rs = 1;
    endtask

    initial begin
        rst = 1'b0;
        clr();
        bus.mem_dst = 5'd5; bus.mem_reg_write = 1; bus.ex_rs = 5'd5;
        #1;
        check("rst_Aforward",  32'(bus.Aforward), 32'd0);
        check("rst_pc_write",  32'(bus.pc_write), 32'd1);
        check("rst_ifid_write", 32'(bus.ifid_write), 32'd1);
        check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        #11 rst = 1'b1;
        clr();

        // Forwarding priority and $0 exclusion
        step();
        bus.mem_dst = 5'd5; bus.mem_reg_write = 1; bus.wb_dst = 5'd5; bus.wb_reg_write = 1;
        bus.ex_rs = 5'd5;
        #1 check("fwdA_mem_over_wb", 32'(bus.Aforward), 32'd2);
        step(); bus.mem_reg_write = 0;
        #1 check("fwdA_wb", 32'(bus.Aforward), 32'd1);
        step(); bus.mem_reg_write = 1; bus.mem_dst = 5'd0; bus.wb_dst = 5'd0; bus.ex_rs = 5'd0;
        #1 check("fwdA_r0", 32'(bus.Aforward), 32'd0);

        // Immediate B operand suppresses forwarding
        step(); clr(); bus.ex_rt = 5'd7; bus.mem_dst = 5'd7; bus.mem_reg_write = 1; bus.ex_alu_src = 1;
        #1 check("fwdB_imm", 32'(bus.Bforward), 32'd0);
        step(); bus.ex_alu_src = 0;
        #1 check("fwdB_mem", 32'(bus.Bforward), 32'd2);

        // Load-use: exactly one bubble
        step(); clr(); load_use(5'd3);
        #1 check("luh_pc_write", 32'(bus.pc_write), 32'd0);
        check("luh_bubble", 32'(bus.idex_bubble), 32'd1);
        step(); clr(); bus.ex_valid = 1; bus.ex_dst = 5'd4; bus.mem_dst = 5'd3; bus.mem_reg_write = 1;
        #1 check("luh_after_pc_write", 32'(bus.pc_write), 32'd1);
        check("luh_after_bubble", 32'(bus.idex_bubble), 32'd0);
        check("luh_stall_cnt", 32'(bus.stall_cnt), 32'd1);
        step(); clr(); load_use(5'd3); bus.id_uses_rs = 0;
        #1 check("luh_unused_src", 32'(bus.pc_write), 32'd1);

        // Multi-cycle op: 3 hold cycles then mc_done
        step(); clr(); bus.ex_valid = 1; bus.ex_mc_op = 1;
        #1 check("mc_hold0", 32'(bus.pipe_hold), 32'd1);
        for (int i = 1; i < MC - 1; i++) begin
            step();
            #1 check("mc_hold", 32'(bus.pipe_hold), 32'd1);
            check("mc_no_done", 32'(bus.mc_done), 32'd0);
        end
        step();
        #1 check("mc_release", 32'(bus.pipe_hold), 32'd0);
        check("mc_done", 32'(bus.mc_done), 32'd1);
        check("mc_stall_cnt", 32'(bus.stall_cnt), 32'd4);
        step(); clr();
        #1 check("mc_done_pulse", 32'(bus.mc_done), 32'd0);

        // Flush aborts MC_BUSY at cnt=1
        step(); bus.ex_valid = 1; bus.ex_mc_op = 1;
        step();
        step(); bus.flush = 1;
        #1 check("fl_ex_flush", 32'(bus.ex_flush), 32'd1);
        check("fl_ifid_flush", 32'(bus.ifid_flush), 32'd1);
        check("fl_pc_write", 32'(bus.pc_write), 32'd1);
        check("fl_hold", 32'(bus.pipe_hold), 32'd0);
        step(); clr();
        #1 check("fl_no_done", 32'(bus.mc_done), 32'd0);
        check("fl_stall_cnt", 32'(bus.stall_cnt), 32'd6);

        // Flush outranks a load-use in RUN
        step(); load_use(5'd9); bus.flush = 1;
        #1 check("fl_luh_pc_write", 32'(bus.pc_write), 32'd1);
        check("fl_luh_ifid_write", 32'(bus.ifid_write), 32'd1);

        // Async reset in the middle of MC_BUSY
        step(); clr(); bus.ex_valid = 1; bus.ex_mc_op = 1;
        step();
        #1 rst = 1'b0;
        #1 check("arst_hold", 32'(bus.pipe_hold), 32'd0);
        check("arst_pc_write", 32'(bus.pc_write), 32'd1);
        check("arst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        clr();
        #4 rst = 1'b1;
        step();
        #1 check("arst_after_hold", 32'(bus.pipe_hold), 32'd0);
        check("arst_after_done", 32'(bus.mc_done), 32'd0);

        // Stall counter saturation
        step(); load_use(5'd3);
        repeat (SMAX + 4) step();
        check("sat_stall_cnt", 32'(bus.stall_cnt), 32'(SMAX));
        clr();
        step(); step();
        #1 check("sat_hold_value", 32'(bus.stall_cnt), 32'(SMAX));

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
